// File: rtl/verificador_senha_if.sv
// Handshake and status bundle between the lock controller and verificador_senha.
// The master side drives the character stream and commands; the slave side returns status.
interface verificador_senha_if #(
  parameter int unsigned N_CHARS = 10,
  parameter int unsigned CHAR_W  = 8,
  parameter int unsigned TENT_W  = 4
);
  localparam int unsigned IDX_W = $clog2(N_CHARS + 1);

  logic              char_valid;
  logic [CHAR_W-1:0] char_data;
  logic              clear_entry;
  logic              start;
  logic              modo;
  logic [TENT_W-1:0] max_tentativas;
  logic              busy;
  logic              done;
  logic              igual;
  logic              entrada_cheia;
  logic              excedeu;
  logic [TENT_W-1:0] db_tentativas;
  logic [IDX_W-1:0]  db_indice;

  modport master (
    output char_valid, char_data, clear_entry, start, modo, max_tentativas,
    input  busy, done, igual, entrada_cheia, excedeu, db_tentativas, db_indice
  );

  modport slave (
    input  char_valid, char_data, clear_entry, start, modo, max_tentativas,
    output busy, done, igual, entrada_cheia, excedeu, db_tentativas, db_indice
  );
endinterface

// File: rtl/verificador_senha.sv
// Password verification engine: buffers a serial code, verifies or programs it against the
// stored code, counts failed attempts and holds a timed lockout after too many failures.
module verificador_senha #(
  parameter int unsigned N_CHARS     = 10,
  parameter int unsigned CHAR_W      = 8,
  parameter int unsigned TENT_W      = 4,
  parameter int unsigned LOCK_CYCLES = 50_000_000
) (
  input logic                clock,
  input logic                reset,
  verificador_senha_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(N_CHARS + 1);
  localparam int unsigned LCK_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [IDX_W-1:0] FULL_PTR  = IDX_W'(N_CHARS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_CHARS - 1);
  localparam logic [LCK_W-1:0] LAST_LOCK = LCK_W'(LOCK_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StCompara, StGrava, StResultado, StBloqueado} state_t;

  state_t                          state_q;
  logic [N_CHARS-1:0][CHAR_W-1:0]  buffer_q;
  logic [N_CHARS-1:0][CHAR_W-1:0]  stored_q;
  logic [IDX_W-1:0]                ptr_q;
  logic [IDX_W-1:0]                idx_q;
  logic [LCK_W-1:0]                lock_q;
  logic [TENT_W-1:0]               tent_q;
  logic                            mismatch_q;
  logic                            busy_q;
  logic                            done_q;
  logic                            igual_q;
  logic                            excedeu_q;

  logic              full;
  logic              fail;
  logic [TENT_W-1:0] tent_inc;
  logic              lock_hit;

  assign full     = (ptr_q == FULL_PTR);
  // Sticky mismatch including the character being compared this cycle.
  assign fail     = mismatch_q | (buffer_q[idx_q] != stored_q[idx_q]);
  assign tent_inc = (tent_q == '1) ? tent_q : tent_q + TENT_W'(1);
  assign lock_hit = (bus.max_tentativas != '0) && (tent_inc >= bus.max_tentativas);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      buffer_q   <= '0;
      stored_q   <= '0;
      ptr_q      <= '0;
      idx_q      <= '0;
      lock_q     <= '0;
      tent_q     <= '0;
      mismatch_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      igual_q    <= 1'b0;
      excedeu_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start && full) begin
            idx_q      <= '0;
            mismatch_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= bus.modo ? StGrava : StCompara;
          end else if (bus.clear_entry) begin
            ptr_q <= '0;
          end else if (bus.char_valid && !full) begin
            buffer_q[ptr_q] <= bus.char_data;
            ptr_q           <= ptr_q + IDX_W'(1);
          end
        end
        StCompara: begin
          if (idx_q == LAST_IDX) begin
            // Result, counter and lockout flag all land on the edge that raises done.
            state_q <= StResultado;
            done_q  <= 1'b1;
            igual_q <= ~fail;
            ptr_q   <= '0;
            if (fail) begin
              tent_q    <= tent_inc;
              excedeu_q <= lock_hit;
            end else begin
              tent_q <= '0;
            end
          end else begin
            mismatch_q <= fail;
            idx_q      <= idx_q + IDX_W'(1);
          end
        end
        StGrava: begin
          stored_q[idx_q] <= buffer_q[idx_q];
          if (idx_q == LAST_IDX) begin
            state_q    <= StResultado;
            done_q     <= 1'b1;
            igual_q    <= 1'b1;
            mismatch_q <= 1'b0;
            ptr_q      <= '0;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        StResultado: begin
          if (excedeu_q) begin
            lock_q  <= '0;
            state_q <= StBloqueado;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StBloqueado: begin
          if (lock_q == LAST_LOCK) begin
            tent_q    <= '0;
            excedeu_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= StIdle;
          end else begin
            lock_q <= lock_q + LCK_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.igual         = igual_q;
  assign bus.entrada_cheia = full;
  assign bus.excedeu       = excedeu_q;
  assign bus.db_tentativas = tent_q;
  assign bus.db_indice     = idx_q;
endmodule

// File: tb/tb_verificador_senha.sv
// Directed bench for verificador_senha: program/verify, failure counting, lockout,
// buffer edge cases, counter saturation and reset during programming.
module tb_verificador_senha;
  localparam int unsigned N    = 10;
  localparam int unsigned LOCK = 20;

  typedef logic [N-1:0][7:0] code_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  verificador_senha_if #(.N_CHARS(N), .CHAR_W(8), .TENT_W(2)) bus ();

  verificador_senha #(.N_CHARS(N), .CHAR_W(8), .TENT_W(2), .LOCK_CYCLES(LOCK)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic code_t seq(input logic [7:0] base);
    code_t c;
    for (int i = 0; i < N; i++) c[i] = base + 8'(i);
    return c;
  endfunction

  task automatic enter_code(input code_t c);
    for (int i = 0; i < N; i++) begin
      bus.char_valid = 1'b1;
      bus.char_data  = c[i];
      tick();
    end
    bus.char_valid = 1'b0;
  endtask

  // Issues start and leaves time in the done cycle; lat counts cycles from the start edge.
  task automatic run_op(input logic m, output int lat, output logic busy1);
    bus.modo  = m;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.modo  = 1'b0;
    busy1 = bus.busy;
    lat   = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    if (bus.done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    logic [10:0] st;
    bus.char_valid = 0; bus.char_data = 0; bus.clear_entry = 0;
    bus.start = 0; bus.modo = 0; bus.max_tentativas = 2'd3;
    reset = 1'b0;
    tick(); tick();
    st = {bus.busy, bus.done, bus.igual, bus.entrada_cheia, bus.excedeu, bus.db_tentativas,
          bus.db_indice};
    n_vec++;
    if (st !== '0) begin n_err++; $display("FAIL reset_outputs: got %h expected 0", st); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_program();
    int lat; logic b1;
    enter_code(seq(8'h31));
    n_vec++;
    if (bus.entrada_cheia !== 1'b1) begin
      n_err++; $display("FAIL prog_full: got %b expected 1", bus.entrada_cheia);
    end
    run_op(1'b1, lat, b1);
    n_vec++;
    if (b1 !== 1'b1) begin n_err++; $display("FAIL prog_busy: got %b expected 1", b1); end
    n_vec++;
    if (lat !== N + 1) begin n_err++; $display("FAIL prog_latency: got %0d expected %0d", lat, N + 1); end
    n_vec++;
    if (bus.igual !== 1'b1 || bus.db_tentativas !== 2'd0) begin
      n_err++; $display("FAIL prog_result: got igual=%b tent=%0d expected 1/0", bus.igual, bus.db_tentativas);
    end
    tick();
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++; $display("FAIL prog_after: got busy=%b done=%b expected 0/0", bus.busy, bus.done);
    end
  endtask

  task automatic test_verify_ok();
    int lat; logic b1;
    enter_code(seq(8'h31));
    run_op(1'b0, lat, b1);
    n_vec++;
    if (lat !== N + 1 || bus.igual !== 1'b1 || bus.db_tentativas !== 2'd0) begin
      n_err++;
      $display("FAIL verify_ok: got lat=%0d igual=%b tent=%0d expected %0d/1/0", lat, bus.igual, bus.db_tentativas, N + 1);
    end
    tick();
  endtask

  task automatic test_wrong_last();
    int lat; logic b1; code_t w;
    w = seq(8'h31); w[N-1] = 8'h30;
    enter_code(w);
    run_op(1'b0, lat, b1);
    n_vec++;
    if (lat !== N + 1) begin n_err++; $display("FAIL wrong_latency: got %0d expected %0d", lat, N + 1); end
    n_vec++;
    if (bus.igual !== 1'b0 || bus.db_tentativas !== 2'd1 || bus.entrada_cheia !== 1'b0 || bus.excedeu !== 1'b0) begin
      n_err++;
      $display("FAIL wrong_result: got igual=%b tent=%0d cheia=%b exc=%b expected 0/1/0/0", bus.igual, bus.db_tentativas, bus.entrada_cheia, bus.excedeu);
    end
    tick();
  endtask

  task automatic test_lockout();
    int lat; logic b1; code_t w; int cnt; logic saw_done;
    w = seq(8'h31); w[N-1] = 8'h30;
    bus.max_tentativas = 2'd3;
    enter_code(seq(8'h31));
    run_op(1'b0, lat, b1);
    n_vec++;
    if (bus.igual !== 1'b1 || bus.db_tentativas !== 2'd0) begin
      n_err++; $display("FAIL lock_clear: got igual=%b tent=%0d expected 1/0", bus.igual, bus.db_tentativas);
    end
    tick();
    for (int k = 1; k <= 3; k++) begin
      enter_code(w);
      run_op(1'b0, lat, b1);
      n_vec++;
      if (lat !== N + 1 || bus.db_tentativas !== 2'(k) || bus.excedeu !== (k == 3)) begin
        n_err++;
        $display("FAIL lock_try%0d: got lat=%0d tent=%0d exc=%b expected %0d/%0d/%b", k, lat, bus.db_tentativas, bus.excedeu, N + 1, k, k == 3);
      end
      if (k < 3) tick();
    end
    // Start and characters during lockout must be ignored.
    bus.start = 1'b1; bus.char_valid = 1'b1; bus.char_data = 8'h31;
    cnt = 0; saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (c == 9) begin bus.start = 1'b0; bus.char_valid = 1'b0; end
      if (bus.done === 1'b1) saw_done = 1'b1;
      if (bus.excedeu !== 1'b1) break;
      cnt++;
    end
    bus.start = 1'b0; bus.char_valid = 1'b0;
    n_vec++;
    if (cnt !== LOCK) begin n_err++; $display("FAIL lock_length: got %0d expected %0d", cnt, LOCK); end
    n_vec++;
    if (saw_done !== 1'b0) begin n_err++; $display("FAIL lock_start_ignored: got done=%b expected 0", saw_done); end
    n_vec++;
    if (bus.busy !== 1'b0 || bus.db_tentativas !== 2'd0 || bus.entrada_cheia !== 1'b0) begin
      n_err++;
      $display("FAIL lock_exit: got busy=%b tent=%0d cheia=%b expected 0/0/0", bus.busy, bus.db_tentativas, bus.entrada_cheia);
    end
  endtask

  task automatic test_buffer_edges();
    int lat; logic b1; code_t c; logic seen_done, seen_busy;
    c = seq(8'h31);
    enter_code(c);
    bus.char_valid = 1'b1; bus.char_data = 8'h00;
    tick();
    bus.char_valid = 1'b0;
    n_vec++;
    if (bus.entrada_cheia !== 1'b1) begin n_err++; $display("FAIL edge_11th_full: got %b expected 1", bus.entrada_cheia); end
    run_op(1'b0, lat, b1);
    n_vec++;
    if (bus.igual !== 1'b1) begin n_err++; $display("FAIL edge_11th_ignored: got igual=%b expected 1", bus.igual); end
    tick();
    for (int i = 0; i < N - 1; i++) begin
      bus.char_valid = 1'b1; bus.char_data = c[i]; tick();
    end
    bus.char_valid = 1'b0;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    seen_done = bus.done; seen_busy = bus.busy;
    for (int i = 0; i < 15; i++) begin
      tick();
      seen_done |= bus.done; seen_busy |= bus.busy;
    end
    n_vec++;
    if (seen_done !== 1'b0 || seen_busy !== 1'b0) begin
      n_err++; $display("FAIL edge_short_start: got done=%b busy=%b expected 0/0", seen_done, seen_busy);
    end
    bus.clear_entry = 1'b1; bus.char_valid = 1'b1; bus.char_data = 8'hFF;
    tick();
    bus.clear_entry = 1'b0; bus.char_valid = 1'b0;
    n_vec++;
    if (bus.entrada_cheia !== 1'b0) begin n_err++; $display("FAIL edge_clear_prio: got cheia=%b expected 0", bus.entrada_cheia); end
    enter_code(c);
    run_op(1'b0, lat, b1);
    n_vec++;
    if (lat !== N + 1 || bus.igual !== 1'b1) begin
      n_err++; $display("FAIL edge_after_clear: got lat=%0d igual=%b expected %0d/1", lat, bus.igual, N + 1);
    end
    tick();
  endtask

  task automatic test_saturation();
    int lat; logic b1; code_t w; logic [1:0] exp_t;
    w = seq(8'h31); w[0] = 8'h00;
    bus.max_tentativas = 2'd0;
    for (int k = 1; k <= 5; k++) begin
      exp_t = (k > 3) ? 2'd3 : 2'(k);
      enter_code(w);
      run_op(1'b0, lat, b1);
      n_vec++;
      if (lat !== N + 1 || bus.igual !== 1'b0 || bus.db_tentativas !== exp_t || bus.excedeu !== 1'b0) begin
        n_err++;
        $display("FAIL sat_try%0d: got lat=%0d igual=%b tent=%0d exc=%b expected %0d/0/%0d/0", k, lat, bus.igual, bus.db_tentativas, bus.excedeu, N + 1, exp_t);
      end
      tick();
      n_vec++;
      if (bus.excedeu !== 1'b0 || bus.busy !== 1'b0) begin
        n_err++; $display("FAIL sat_nolock%0d: got exc=%b busy=%b expected 0/0", k, bus.excedeu, bus.busy);
      end
    end
  endtask

  task automatic test_reset_mid_grava();
    int lat; logic b1; logic [10:0] st; int c;
    enter_code(seq(8'h61));
    bus.modo = 1'b1; bus.start = 1'b1; tick(); bus.start = 1'b0; bus.modo = 1'b0;
    c = 0;
    while (bus.db_indice !== 4'd4 && c < 20) begin tick(); c++; end
    n_vec++;
    if (bus.db_indice !== 4'd4 || bus.busy !== 1'b1) begin
      n_err++; $display("FAIL midrst_reach: got idx=%0d busy=%b expected 4/1", bus.db_indice, bus.busy);
    end
    reset = 1'b0;
    #1;
    st = {bus.busy, bus.done, bus.igual, bus.entrada_cheia, bus.excedeu, bus.db_tentativas,
          bus.db_indice};
    n_vec++;
    if (st !== '0) begin n_err++; $display("FAIL midrst_outputs: got %h expected 0", st); end
    tick();
    reset = 1'b1;
    tick();
    enter_code('0);
    run_op(1'b0, lat, b1);
    n_vec++;
    if (lat !== N + 1 || bus.igual !== 1'b1 || bus.db_tentativas !== 2'd0) begin
      n_err++;
      $display("FAIL midrst_zero_code: got lat=%0d igual=%b tent=%0d expected %0d/1/0", lat, bus.igual, bus.db_tentativas, N + 1);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_program();
    test_verify_ok();
    test_wrong_last();
    test_lockout();
    test_buffer_edges();
    test_saturation();
    test_reset_mid_grava();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
